// File: rtl/riscv_fetch.sv
// riscv_fetch
// Instruction-fetch stage plus IF/ID pipeline register of the 5-stage core.
// Keeps the fetch PC, drives a req/ack instruction-memory handshake of any
// latency, including zero-wait, and applies execute-stage redirects. It
// presents instruction, PC and PC+4 to decode. If decode stalls while a
// response lands, a one-entry hold buffer parks that response, so no fetched
// word is lost or duplicated.
//
// Ports
//   iclk, irst         clock; synchronous active-high reset
//   istall_d           hold IF/ID and freeze fetch advance
//   iflush_d           replace IF/ID with a bubble
//   ipc_src            redirect from execute, target in ipc_target_e
//   oimem_req/addr     fetch request; address held stable until ack
//   iimem_ack/rdata    memory response, may coincide with the request
//   oinstr_d, opc_d, opc_plus4_d, ovalid_d   IF/ID contents
module riscv_fetch #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter logic [31:0]     NOP      = 32'h0000_0013
) (
  input  logic            iclk,
  input  logic            irst,
  input  logic            istall_d,
  input  logic            iflush_d,
  input  logic            ipc_src,
  input  logic [XLEN-1:0] ipc_target_e,
  output logic            oimem_req,
  output logic [XLEN-1:0] oimem_addr,
  input  logic            iimem_ack,
  input  logic [31:0]     iimem_rdata,
  output logic [31:0]     oinstr_d,
  output logic [XLEN-1:0] opc_d,
  output logic [XLEN-1:0] opc_plus4_d,
  output logic            ovalid_d
);

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    DROP  = 2'd2
  } state_t;

  state_t state;
  state_t state_next;

  logic [XLEN-1:0] pc_f;
  logic [XLEN-1:0] pc_f_next;
  logic [XLEN-1:0] drop_addr;
  logic [XLEN-1:0] drop_addr_next;
  logic [31:0]     buf_instr;
  logic [31:0]     buf_instr_next;
  logic [XLEN-1:0] buf_pc;
  logic [XLEN-1:0] buf_pc_next;
  logic [31:0]     instr_d_next;
  logic [XLEN-1:0] pc_d_next;
  logic [XLEN-1:0] pc_plus4_d_next;
  logic            valid_d_next;

  logic [XLEN-1:0] pc_plus4_f;
  logic [XLEN-1:0] target_aligned;
  logic            fetch_ack;
  logic            load_fetch;
  logic            load_hold;
  logic [1:0]      unused_target_bits;

  assign pc_plus4_f         = pc_f + XLEN'(4);
  assign target_aligned     = {ipc_target_e[XLEN-1:2], 2'b00};
  assign unused_target_bits = ipc_target_e[1:0];

  // A response only means something to us while a live request is out.
  assign fetch_ack  = (state == FETCH) && iimem_ack;
  // A redirect in the same cycle discards whatever would have been loaded.
  assign load_fetch = fetch_ack && !ipc_src;
  assign load_hold  = (state == HOLD) && !ipc_src;

  // State register
  always_ff @(posedge iclk) begin
    if (irst) begin
      state <= FETCH;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      FETCH: begin
        if (ipc_src) begin
          // Without an ack the old request is still in flight and must be
          // allowed to complete before the target can be requested.
          state_next = iimem_ack ? FETCH : DROP;
        end else if (iimem_ack && istall_d) begin
          state_next = HOLD;
        end
      end
      HOLD: begin
        if (ipc_src || !istall_d) begin
          state_next = FETCH;
        end
      end
      DROP: begin
        if (iimem_ack) begin
          state_next = FETCH;
        end
      end
      default: state_next = FETCH;
    endcase
  end

  // Output logic
  always_comb begin
    oimem_req  = 1'b0;
    oimem_addr = {pc_f[XLEN-1:2], 2'b00};
    if (!irst) begin
      case (state)
        FETCH: oimem_req = 1'b1;
        DROP: begin
          oimem_req  = 1'b1;
          oimem_addr = {drop_addr[XLEN-1:2], 2'b00};
        end
        default: oimem_req = 1'b0;
      endcase
    end
  end

  // Fetch PC, drop address and hold buffer
  always_comb begin
    pc_f_next      = pc_f;
    drop_addr_next = drop_addr;
    buf_instr_next = buf_instr;
    buf_pc_next    = buf_pc;

    if (ipc_src) begin
      pc_f_next = target_aligned;
      // Remember the in-flight address only on entry to DROP; while already
      // in DROP the original stale address must stay on the bus.
      if (state == FETCH && !iimem_ack) begin
        drop_addr_next = pc_f;
      end
    end else if (fetch_ack && !istall_d) begin
      // Advances even under iflush_d: the word is consumed, just not kept.
      pc_f_next = pc_plus4_f;
    end else if (load_hold && !istall_d) begin
      pc_f_next = pc_plus4_f;
    end

    if (load_fetch && istall_d) begin
      buf_instr_next = iimem_rdata;
      buf_pc_next    = pc_f;
    end
  end

  // IF/ID next value: flush beats stall beats load beats bubble.
  always_comb begin
    instr_d_next    = oinstr_d;
    pc_d_next       = opc_d;
    pc_plus4_d_next = opc_plus4_d;
    valid_d_next    = ovalid_d;
    if (iflush_d) begin
      instr_d_next = NOP;
      valid_d_next = 1'b0;
    end else if (istall_d) begin
      valid_d_next = ovalid_d;
    end else if (load_fetch) begin
      instr_d_next    = iimem_rdata;
      pc_d_next       = pc_f;
      pc_plus4_d_next = pc_plus4_f;
      valid_d_next    = 1'b1;
    end else if (load_hold) begin
      instr_d_next    = buf_instr;
      pc_d_next       = buf_pc;
      pc_plus4_d_next = buf_pc + XLEN'(4);
      valid_d_next    = 1'b1;
    end else begin
      instr_d_next = NOP;
      valid_d_next = 1'b0;
    end
  end

  // Datapath registers
  always_ff @(posedge iclk) begin
    if (irst) begin
      pc_f        <= RESET_PC;
      drop_addr   <= '0;
      buf_instr   <= NOP;
      buf_pc      <= '0;
      oinstr_d    <= NOP;
      opc_d       <= RESET_PC;
      opc_plus4_d <= RESET_PC + XLEN'(4);
      ovalid_d    <= 1'b0;
    end else begin
      pc_f        <= pc_f_next;
      drop_addr   <= drop_addr_next;
      buf_instr   <= buf_instr_next;
      buf_pc      <= buf_pc_next;
      oinstr_d    <= instr_d_next;
      opc_d       <= pc_d_next;
      opc_plus4_d <= pc_plus4_d_next;
      ovalid_d    <= valid_d_next;
    end
  end

endmodule
